// File: rtl/alu_core.sv
// RV32I execute-stage ALU with a single registered output stage (one cycle latency).
// Optional flag outputs (carry, overflow, negative) are built when ALU_FLAGS_EN is defined.
module alu_core #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
`ifdef ALU_FLAGS_EN
    output logic            carry,
    output logic            overflow,
    output logic            negative,
`endif
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [3:0] {
        OpAdd  = 4'b0000,
        OpSub  = 4'b0001,
        OpAnd  = 4'b0010,
        OpOr   = 4'b0011,
        OpXor  = 4'b0100,
        OpSll  = 4'b0101,
        OpSrl  = 4'b0110,
        OpSra  = 4'b0111,
        OpSltu = 4'b1000,
        OpSlt  = 4'b1001
    } alu_op_e;

    logic [XLEN:0]        sum_ext;
    logic [XLEN:0]        diff_ext;
    logic [SHAMT_W-1:0]   shamt;
    logic                 lt_signed;
    logic                 lt_unsigned;
    logic [XLEN-1:0]      result_d;
    logic                 zero_d;

    logic                 out_valid_q;
    logic [XLEN-1:0]      result_q;
    logic                 zero_q;

    // Extra top bit of the difference is the borrow out of the subtraction.
    assign sum_ext     = {1'b0, a} + {1'b0, b};
    assign diff_ext    = {1'b0, a} - {1'b0, b};
    assign shamt       = b[SHAMT_W-1:0];
    assign lt_unsigned = diff_ext[XLEN];
    assign lt_signed   = $signed(a) < $signed(b);

    always_comb begin
        result_d = '0;
        case (alu_op)
            OpAdd:   result_d = sum_ext[XLEN-1:0];
            OpSub:   result_d = diff_ext[XLEN-1:0];
            OpAnd:   result_d = a & b;
            OpOr:    result_d = a | b;
            OpXor:   result_d = a ^ b;
            OpSll:   result_d = a << shamt;
            OpSrl:   result_d = a >> shamt;
            OpSra:   result_d = $unsigned($signed(a) >>> shamt);
            OpSltu:  result_d = {{(XLEN-1){1'b0}}, lt_unsigned};
            OpSlt:   result_d = {{(XLEN-1){1'b0}}, lt_signed};
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

`ifdef ALU_FLAGS_EN
    logic carry_d, overflow_d;
    logic carry_q, overflow_q, negative_q;

    always_comb begin
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (alu_op)
            OpAdd: begin
                carry_d    = sum_ext[XLEN];
                overflow_d = (a[XLEN-1] == b[XLEN-1]) && (sum_ext[XLEN-1] != a[XLEN-1]);
            end
            OpSub: begin
                // Carry means "no borrow", i.e. a >= b unsigned.
                carry_d    = ~diff_ext[XLEN];
                overflow_d = (a[XLEN-1] != b[XLEN-1]) && (diff_ext[XLEN-1] != a[XLEN-1]);
            end
            default: begin
                carry_d    = 1'b0;
                overflow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
        end else if (in_valid) begin
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            negative_q <= result_d[XLEN-1];
        end
    end

    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign negative = negative_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed plan steps followed by randomized operations
// checked against an arithmetic reference model.
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_FLAGS_EN
    logic        carry, overflow, negative;
    logic        exp_carry, exp_ovf, exp_neg;
`endif

    int checks = 0;
    int errors = 0;

    logic        exp_valid;
    logic [31:0] exp_result;
    logic        exp_zero;

    alu_core #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
`ifdef ALU_FLAGS_EN
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
`endif
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] x,
                                                 input logic [31:0] y);
        int unsigned s;
        logic [31:0] fill;
        s = y % 32;
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return x << s;
            4'd6: return x >> s;
            4'd7: begin
                fill = x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
                return (x >> s) | fill;
            end
            4'd8: return (x < y) ? 32'd1 : 32'd0;
            // Flipping the sign bit maps signed order onto unsigned order.
            4'd9: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic model_carry(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
        longint unsigned s;
        s = longint'(x) + longint'(y);
        if (op == 4'd0) return s >= 64'h1_0000_0000;
        if (op == 4'd1) return x >= y;
        return 1'b0;
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] x,
                                       input logic [31:0] y);
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 4'd0) r = sx + sy;
        else if (op == 4'd1) r = sx - sy;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, update the reference state, then compare just after the edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] op,
                        input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        alu_op   = op;
        a        = x;
        b        = y;
        @(posedge clk);
        if (!r) begin
            exp_valid  = 1'b0;
            exp_result = 32'h0;
            exp_zero   = 1'b0;
`ifdef ALU_FLAGS_EN
            exp_carry = 1'b0;
            exp_ovf   = 1'b0;
            exp_neg   = 1'b0;
`endif
        end else if (v) begin
            exp_valid  = 1'b1;
            exp_result = model_result(op, x, y);
            exp_zero   = (exp_result == 32'h0);
`ifdef ALU_FLAGS_EN
            exp_carry = model_carry(op, x, y);
            exp_ovf   = model_ovf(op, x, y);
            exp_neg   = exp_result[31];
`endif
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        check({tag, ".valid"}, {31'h0, out_valid}, {31'h0, exp_valid});
        check({tag, ".result"}, result, exp_result);
        if (r && v) check({tag, ".zero"}, {31'h0, zero}, {31'h0, exp_zero});
        if (!r) check({tag, ".zero"}, {31'h0, zero}, 32'h0);
`ifdef ALU_FLAGS_EN
        if (!r || v) begin
            check({tag, ".carry"}, {31'h0, carry}, {31'h0, exp_carry});
            check({tag, ".ovf"}, {31'h0, overflow}, {31'h0, exp_ovf});
            check({tag, ".neg"}, {31'h0, negative}, {31'h0, exp_neg});
        end
`endif
    endtask

    initial begin
        logic [31:0] held;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        rv;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = 4'h0;
        a        = 32'h0;
        b        = 32'h0;
        exp_valid  = 1'b0;
        exp_result = 32'h0;
        exp_zero   = 1'b0;

        step("reset0", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("reset1", 1'b0, 1'b1, 4'h0, 32'h3, 32'h4);

        step("add", 1'b1, 1'b1, 4'b0000, 32'd10, 32'd5);
        check("add.lit", result, 32'h0000_000F);
        step("sub", 1'b1, 1'b1, 4'b0001, 32'd10, 32'd5);
        check("sub.lit", result, 32'h0000_0005);
        step("and", 1'b1, 1'b1, 4'b0010, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("and.lit", result, 32'h0F00_0F00);
        step("or", 1'b1, 1'b1, 4'b0011, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("or.lit", result, 32'hFF0F_FF0F);
        step("xor", 1'b1, 1'b1, 4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("xor.lit", result, 32'hF00F_F00F);
        step("sll", 1'b1, 1'b1, 4'b0101, 32'd1, 32'd3);
        check("sll.lit", result, 32'h0000_0008);
        step("srl", 1'b1, 1'b1, 4'b0110, 32'd16, 32'd2);
        check("srl.lit", result, 32'h0000_0004);
        step("sra", 1'b1, 1'b1, 4'b0111, 32'hFFFF_FFF0, 32'd2);
        check("sra.lit", result, 32'hFFFF_FFFC);
        step("sll_hi", 1'b1, 1'b1, 4'b0101, 32'd1, 32'h0000_0021);
        check("sll_hi.lit", result, 32'h0000_0002);
        step("sll0", 1'b1, 1'b1, 4'b0101, 32'h1234_5678, 32'h0000_0020);
        check("sll0.lit", result, 32'h1234_5678);
        step("sltu", 1'b1, 1'b1, 4'b1000, 32'd1, 32'd2);
        check("sltu.lit", result, 32'h1);
        step("slt_neg", 1'b1, 1'b1, 4'b1001, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg.lit", result, 32'h1);
        step("sltu_big", 1'b1, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1);
        check("sltu_big.lit", result, 32'h0);
        step("slt_eq", 1'b1, 1'b1, 4'b1001, 32'd5, 32'd5);
        check("slt_eq.lit", result, 32'h0);
        check("slt_eq.zero", {31'h0, zero}, 32'h1);
        step("add_wrap", 1'b1, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap.lit", result, 32'h0);
        check("add_wrap.zero", {31'h0, zero}, 32'h1);
        step("sub_wrap", 1'b1, 1'b1, 4'b0001, 32'd0, 32'd1);
        check("sub_wrap.lit", result, 32'hFFFF_FFFF);
        step("rsvd", 1'b1, 1'b1, 4'b1100, 32'hDEAD_BEEF, 32'h1234_5678);
        check("rsvd.lit", result, 32'h0);
        check("rsvd.zero", {31'h0, zero}, 32'h1);
        step("add_ovf", 1'b1, 1'b1, 4'b0000, 32'h7FFF_FFFF, 32'd1);
        check("add_ovf.lit", result, 32'h8000_0000);
`ifdef ALU_FLAGS_EN
        check("add_ovf.ovf", {31'h0, overflow}, 32'h1);
        check("add_ovf.neg", {31'h0, negative}, 32'h1);
        check("add_ovf.carry", {31'h0, carry}, 32'h0);
`endif

        // Idle cycle: valid drops, result holds.
        held = result;
        step("idle", 1'b1, 1'b0, 4'b0000, 32'd1, 32'd1);
        check("idle.hold", result, held);
        check("idle.valid", {31'h0, out_valid}, 32'h0);

        step("pre_rst", 1'b1, 1'b1, 4'b0011, 32'hA5A5_0000, 32'h0000_5A5A);
        step("mid_rst", 1'b0, 1'b1, 4'b0011, 32'hFFFF_FFFF, 32'h1);
        check("mid_rst.lit", result, 32'h0);

        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 7) != 0);
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            step("rand", ($urandom_range(0, 49) != 0), rv, rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the RV32I datapath execute stage. Computes add/sub, bitwise logic, shifts and set-less-than on two operands selected by a 4-bit op code.
- Single registered output stage: one cycle latency, valid-qualified.
- Feeds writeback and branch/compare logic.

Parameters:
- XLEN, 32, operand/result width. Only 32 is required to be supported.
- SHAMT_W, 5, shift amount width; equals log2(XLEN).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/op valid this cycle
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2 or immediate)
- alu_op  input  4  operation select
- out_valid  output  1  result valid, one cycle after in_valid
- result  output  XLEN  registered result
- zero  output  1  registered; high when result == 0 and out_valid is high

Behaviour:
- Reset: sampled on clk rising edge while rst_n=0. out_valid=0, result=0, zero=0. Reset takes priority over in_valid in the same cycle, and any in-flight result is discarded.
- Latency: operands sampled at edge N with in_valid=1. result, zero and out_valid=1 are visible after edge N.
- No back-pressure. A new operation is accepted every cycle.
- in_valid=0 at an edge: out_valid goes to 0; result and zero hold their previous values.
- Op encoding (all arithmetic modulo 2^XLEN):
  - 0000 ADD: a+b, carry dropped
  - 0001 SUB: a-b, two's complement wrap
  - 0010 AND: a&b
  - 0011 OR: a|b
  - 0100 XOR: a^b
  - 0101 SLL: a << b[4:0]
  - 0110 SRL: a >> b[4:0], zero fill
  - 0111 SRA: a >>> b[4:0], sign fill from a[31]
  - 1000 SLTU: result 1 if a<b unsigned, else 0
  - 1001 SLT: result 1 if a<b signed, else 0
  - 1010-1111: reserved; result=0 (zero=1), no error
- Shifts use only b[4:0]; b[31:5] are ignored (e.g. b=32'h21 shifts by 1). Shift by 0 returns a unchanged.
- SLT/SLTU return 0 when a==b.
- zero is computed from the next-result value and registered together with it.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: adds registered outputs carry, overflow, negative, each 1 bit, updated under the same rules as zero.
  - carry: carry-out of ADD; for SUB, 1 when no borrow (a >= b unsigned).
  - overflow: signed overflow of ADD/SUB.
  - negative: result[31].
  - For all non-ADD/SUB ops, carry and overflow are 0.
  - All three reset to 0.
- Not defined: these ports and their logic do not exist; base behaviour is unchanged.

Test Plan:
- Reset then ADD a=10, b=5 with in_valid=1 -> next cycle result=0000000F, out_valid=1, zero=0. SUB with the same operands -> 00000005.
- Logic ops with a=FF00FF00, b=0F0F0F0F:
  - AND -> 0F000F00
  - OR -> FF0FFF0F
  - XOR -> F00FF00F
- Shifts:
  - SLL a=1, b=3 -> 00000008
  - SRL a=16, b=2 -> 00000004
  - SRA a=FFFFFFF0, b=2 -> FFFFFFFC
  - SLL a=1, b=00000021 -> 00000002 (upper bits of b ignored)
- Compares:
  - SLTU a=1, b=2 -> 1
  - SLT a=FFFFFFFF, b=1 -> 1
  - SLTU a=FFFFFFFF, b=1 -> 0
  - SLT a=5, b=5 -> 0, zero=1
- Wrap and reserved ops:
  - ADD FFFFFFFF+1 -> 0, zero=1
  - SUB 0-1 -> FFFFFFFF
  - op 1100 -> result=0
  - With ALU_FLAGS_EN: ADD 7FFFFFFF+1 -> overflow=1, negative=1, carry=0
- Control: back-to-back ops on consecutive cycles each appear one cycle later. in_valid=0 drops out_valid and holds result. rst_n=0 asserted mid-stream clears out_valid/result/zero at the next edge, even with in_valid=1.
